// File: rtl/piso_shift_reader.sv
// rtl/piso_shift_reader.sv - parallel-in serial-out word reader with load handshake and last-bit flag
module piso_shift_reader #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             at_last;
    logic             accept;
    logic             out_bit_nxt;
    logic             last_nxt;

    // The word's final bit is on the wire whenever we are shifting with cnt at its top value
    assign at_last    = (state == SHIFT) && (cnt == LAST_CNT);
    // Ready either from idle, or on the final enabled bit so the next word follows with no gap
    assign load_ready = (state == IDLE) || (at_last && shift_en);
    assign accept     = load_valid && load_ready;

    // Next-state, next shift-register contents and the values the output flops will take
    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                    sreg_nxt  = data_in;
                    cnt_nxt   = '0;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (!at_last) begin
                        sreg_nxt = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
                        cnt_nxt  = cnt + CW'(1);
                    end else if (accept) begin
                        sreg_nxt = data_in;
                        cnt_nxt  = '0;
                    end else begin
                        state_nxt = IDLE;
                        sreg_nxt  = '0;
                        cnt_nxt   = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                sreg_nxt  = '0;
                cnt_nxt   = '0;
            end
        endcase

        out_bit_nxt = IDLE_LEVEL;
        last_nxt    = 1'b0;
        if (state_nxt == SHIFT) begin
            out_bit_nxt = MSB_FIRST ? sreg_nxt[WIDTH-1] : sreg_nxt[0];
            last_nxt    = (cnt_nxt == LAST_CNT);
        end
    end

    // State, datapath and output registers; reset discards any word in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sreg      <= '0;
            cnt       <= '0;
            ser_out   <= IDLE_LEVEL;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            sreg      <= sreg_nxt;
            cnt       <= cnt_nxt;
            ser_out   <= out_bit_nxt;
            ser_valid <= (state_nxt == SHIFT);
            ser_last  <= last_nxt;
            busy      <= (state_nxt == SHIFT);
        end
    end

endmodule

// File: doc/piso_shift_reader.md
# piso_shift_reader

Parallel-in, serial-out reader for words held in the team's latch-based storage blocks. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per enabled clock, MSB or LSB first. It also flags the last bit of each word. It sits between a parallel holding stage (D-latch/register bank) and any bit-serial consumer. It supports stalling and gapless back-to-back words.

## Interface
- WIDTH, 8, word length in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first.
- IDLE_LEVEL, 0, value driven on ser_out when no word is being shifted.

- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- load_valid  input  1  data_in holds a word to load.
- load_ready  output  1  block will accept data_in this cycle (combinational).
- data_in  input  WIDTH  parallel word; sampled only on an accepted load.
- shift_en  input  1  advance one bit this cycle; 0 = stall, hold all outputs.
- ser_out  output  1  current serial bit (registered).
- ser_valid  output  1  ser_out carries a word bit (registered).
- ser_last  output  1  ser_out is the final bit of the word (registered).
- busy  output  1  state is SHIFT (registered).

## Operation
- Two states: IDLE, SHIFT. Internal WIDTH-bit shift register sreg, bit counter cnt of width clog2(WIDTH), counting 0..WIDTH-1.
- Accept = load_valid && load_ready.
- load_ready = (state==IDLE) || (state==SHIFT && ser_last && shift_en).
- IDLE:
  - On accept: sreg <= data_in, cnt <= 0, go to SHIFT.
  - Otherwise stay IDLE with ser_out = IDLE_LEVEL and ser_valid = 0.
  - shift_en is ignored in IDLE.
- SHIFT:
  - ser_out = sreg[WIDTH-1] if MSB_FIRST, else sreg[0].
  - ser_last = (cnt==WIDTH-1).
  - shift_en=1 and not last: sreg shifts toward the output end (zero fill) and cnt increments.
  - shift_en=1 and last, with accept in the same cycle: reload from data_in, cnt <= 0, stay SHIFT. No gap cycle.
  - shift_en=1 and last, no accept: go to IDLE.
  - shift_en=0: sreg, cnt, state and all outputs hold. load_valid is not accepted.
- load_valid while busy and not on the last enabled bit: not accepted. data_in is ignored and the producer must hold it.
- No wrap-around of cnt past WIDTH-1; cnt never exceeds WIDTH-1.

## Timing
- Reset (async assert, any time including mid-word):
  - state=IDLE, sreg=0, cnt=0.
  - ser_out=IDLE_LEVEL, ser_valid=0, ser_last=0, busy=0.
  - load_ready=1 once rst deasserts. The in-flight word is discarded, with no partial completion.
- Load latency: accept at edge k; first bit on ser_out, ser_valid=1 and busy=1 after edge k.
- A word needs exactly WIDTH cycles with shift_en=1 after the load.
  - With shift_en held high, ser_valid is high for WIDTH consecutive cycles.
  - ser_last is high during the WIDTH-th cycle only.
- After the last enabled bit with no reload: ser_valid, ser_last and busy drop and ser_out = IDLE_LEVEL from the next edge.
- Back-to-back: the next word's first bit follows the previous last bit on the immediately following cycle. Throughput is 1 bit/cycle sustained.
- load_ready is combinational from state, cnt and shift_en. There is no combinational path from load_valid or data_in to any output.

## Test plan
- Reset: assert rst asynchronously mid-cycle -> all outputs take their reset values immediately, before the next clk edge; load_ready=1 after release.
- MSB_FIRST=1, WIDTH=8, load 8'hA5, shift_en=1 -> ser_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles; ser_last only on the 8th; busy=0 and ser_out=0 on the 9th.
- MSB_FIRST=0, load 8'hA5 -> ser_out 1,0,1,0,0,1,0,1 (LSB first: bits 0..7). Then load 8'h01 -> 1 followed by seven 0s.
- Stall: load 8'hC3 and drop shift_en for 3 cycles after the 2nd bit -> ser_out holds 1 with ser_valid=1 during the stall; the full sequence is 1,1,0,0,0,0,1,1 with total span 11 cycles.
- Back-to-back: hold load_valid with 8'hFF then 8'h00 -> 16 contiguous valid cycles (eight 1s then eight 0s); load_ready pulses on the 8th bit; ser_last on cycles 8 and 16.
- Busy/reset mid-word:
  - Present load_valid with 8'h55 during bit 3 of 8'hF0 -> not accepted, and 8'hF0 completes unchanged.
  - Assert rst on bit 4 -> ser_valid=0 immediately.
  - A following load of 8'h81 shifts out 1,0,0,0,0,0,0,1 cleanly.
